// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one 8-bit async SRAM as 16-bit words
// Each granted word access is split into a low-byte and a high-byte SRAM cycle.
module sram_arbiter #(
   parameter int N_REQ         = 3,
   parameter int ACCESS_CYCLES = 2,
   parameter int ADDR_W        = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*16-1:0]     req_wdata,
   output logic [N_REQ-1:0]        ack,
   output logic [15:0]             rdata,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic [ADDR_W:0]         sram_addr,
   inout  wire  [7:0]              sram_data,
   output logic                    sram_ce,
   output logic                    sram_we,
   output logic                    sram_oe
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(ACCESS_CYCLES);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  win_idx;
   logic              win_found;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [15:0]       win_wdata;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [15:0]       lat_wdata;
   logic [7:0]        lo_byte;
   logic [7:0]        data_out;
   logic              data_oe;
   logic              phase_last;
   logic              phase_end;
   int                cand;

   assign sram_data  = data_oe ? data_out : 8'bz;
   assign phase_last = (cnt == CNT_W'(ACCESS_CYCLES - 2));
   assign phase_end  = (cnt == CNT_W'(ACCESS_CYCLES - 1));

   // Search starts one past the previous owner, so a requester holding req is served last.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(last_grant) + i) % N_REQ;
         if (!win_found && req[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   assign win_we    = req_we[win_idx];
   assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_wdata = req_wdata[int'(win_idx)*16 +: 16];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= IDX_W'(N_REQ - 1);
         ack        <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         rdata      <= '0;
         sram_addr  <= '0;
         sram_ce    <= 1'b1;
         sram_we    <= 1'b1;
         sram_oe    <= 1'b1;
         data_oe    <= 1'b0;
         data_out   <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lo_byte    <= '0;
      end else begin
         case (state)
            IDLE: if (win_found) begin
               grant      <= N_REQ'(1) << win_idx;
               last_grant <= win_idx;
               busy       <= 1'b1;
               lat_we     <= win_we;
               lat_addr   <= win_addr;
               lat_wdata  <= win_wdata;
               cnt        <= '0;
               sram_ce    <= 1'b0;
               sram_addr  <= {win_addr, 1'b0};
               data_out   <= win_wdata[7:0];
               data_oe    <= win_we;
               sram_we    <= !win_we;
               sram_oe    <= win_we;
               state      <= LO;
            end
            LO: begin
               cnt <= cnt + 1'b1;
               // Raising we one cycle early gives address/data hold at the end of the write.
               if (lat_we && phase_last) sram_we <= 1'b1;
               if (phase_end) begin
                  lo_byte   <= sram_data;
                  cnt       <= '0;
                  sram_addr <= {lat_addr, 1'b1};
                  data_out  <= lat_wdata[15:8];
                  sram_we   <= !lat_we;
                  state     <= HI;
               end
            end
            HI: begin
               cnt <= cnt + 1'b1;
               if (lat_we && phase_last) sram_we <= 1'b1;
               if (phase_end) begin
                  if (!lat_we) rdata <= {sram_data, lo_byte};
                  cnt     <= '0;
                  ack     <= grant;
                  sram_ce <= 1'b1;
                  sram_we <= 1'b1;
                  sram_oe <= 1'b1;
                  data_oe <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               ack   <= '0;
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - sram_arbiter bench: directed cases plus random traffic vs a transaction model
module tb_sram_arbiter;
   localparam int N = 3, A = 2, AW = 20, A3 = 3;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic          reset = 1'b1;
   logic [N-1:0]  req = '0, req_we = '0;
   logic [AW-1:0] addr_v [N];
   logic [15:0]   wdata_v [N];
   logic [N*AW-1:0] req_addr;
   logic [N*16-1:0] req_wdata;
   logic [N-1:0]  ack, grant;
   logic [15:0]   rdata;
   logic          busy, sram_ce, sram_we, sram_oe;
   logic [AW:0]   sram_addr;
   wire  [7:0]    sram_data;

   logic [N-1:0]    req3 = '0, req_we3 = '0;
   logic [N*AW-1:0] req_addr3 = '0;
   logic [N*16-1:0] req_wdata3 = '0;
   logic [N-1:0]    ack3, grant3;
   logic [15:0]     rdata3;
   logic            busy3, ce3, we3, oe3;
   logic [AW:0]     addr3;
   wire  [7:0]      data3;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_addr[g*AW +: AW]  = addr_v[g];
      assign req_wdata[g*16 +: 16] = wdata_v[g];
   end

   sram_arbiter #(.N_REQ(N), .ACCESS_CYCLES(A), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
      .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce(sram_ce),
      .sram_we(sram_we), .sram_oe(sram_oe));

   sram_arbiter #(.N_REQ(N), .ACCESS_CYCLES(A3), .ADDR_W(AW)) dut3 (
      .clk(clk), .reset(reset), .req(req3), .req_we(req_we3), .req_addr(req_addr3),
      .req_wdata(req_wdata3), .ack(ack3), .rdata(rdata3), .grant(grant3), .busy(busy3),
      .sram_addr(addr3), .sram_data(data3), .sram_ce(ce3),
      .sram_we(we3), .sram_oe(oe3));

   // Byte-wide async SRAM: drives the bus on read, commits a write when we rises.
   logic [7:0]  mem [0:(1<<21)-1];
   logic        wr_pend = 1'b0;
   logic [AW:0] wa;
   logic [7:0]  wd;
   assign sram_data = (!sram_ce && !sram_oe) ? mem[sram_addr] : 8'bz;
   always @(negedge clk) begin
      if (!sram_ce && !sram_we) begin
         wr_pend <= 1'b1;
         wa      <= sram_addr;
         wd      <= sram_data;
      end else if (wr_pend && sram_we) begin
         mem[wa] <= wd;
         wr_pend <= 1'b0;
      end
   end

   int n_chk = 0, n_pass = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Transaction model: a grant occupies 2A+1 cycles, then one turnaround cycle.
   int            cyc = 0, m_free_at = 0, m_owner = -1, m_last = N-1, m_g = 0;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [15:0]   m_wdata;
   logic [N-1:0]  m_ack;
   logic [15:0]   m_mem [int];

   task automatic step();
      int k, pos, c;
      logic hi;
      logic [N-1:0] oh;
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_owner = -1; m_last = N-1; m_free_at = cyc + 1;
      end else if (m_owner < 0 && cyc >= m_free_at && req != '0) begin
         for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (req[c]) begin
               m_owner = c; m_g = cyc; m_last = c; m_free_at = cyc + 2*A + 2;
               m_we = req_we[c]; m_addr = addr_v[c]; m_wdata = wdata_v[c];
               break;
            end
         end
      end
      @(negedge clk);
      m_ack = '0;
      if (m_owner >= 0) begin
         k  = cyc - m_g;
         oh = N'(1) << m_owner;
         check("grant", grant, oh);
         check("busy", busy, 1);
         check("ack", ack, (k == 2*A) ? oh : '0);
         if (k < 2*A) begin
            hi  = (k >= A);
            pos = k % A;
            check("sram_addr", sram_addr, {m_addr, hi});
            check("ce_oe_we", {sram_ce, sram_oe, sram_we}, {1'b0, m_we, m_we ? (pos == A-1) : 1'b1});
            if (m_we) check("wr_byte", sram_data, hi ? m_wdata[15:8] : m_wdata[7:0]);
         end else begin
            check("done_ctl", {sram_ce, sram_oe, sram_we}, 3'b111);
            if (!m_we) check("rdata", rdata, m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : 16'h0);
            else m_mem[int'(m_addr)] = m_wdata;
            m_ack = oh;
            m_owner = -1;
         end
      end else begin
         check("idle_grant", grant, 0);
         check("idle_busy_ack", {busy, ack}, 0);
         check("idle_ctl", {sram_ce, sram_oe, sram_we}, 3'b111);
      end
   endtask

   task automatic run_one(input int i, input bit we, input logic [AW-1:0] a, input logic [15:0] d);
      int j;
      req_we[i] = we; addr_v[i] = a; wdata_v[i] = d; req[i] = 1'b1;
      for (j = 1; j <= 40; j++) begin
         step();
         if (ack[i]) break;
      end
      req[i] = 1'b0;
      check("ack_latency", j, 2*A + 1);
   endtask

   task automatic drain();
      req = '0;
      repeat (2*A + 3) step();
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0;
      step(); step();
      reset = 1'b0;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] pool [8];
      pool = '{20'h00010, 20'h00011, 20'h00012, 20'h00003, 20'h7FFFF, 20'hFFFFF, 20'h00040, 20'h00041};
      return pool[$urandom_range(7, 0)];
   endfunction

   task automatic new_op(input int i);
      req_we[i]  = 1'($urandom_range(1, 0));
      addr_v[i]  = pick_addr();
      wdata_v[i] = 16'($urandom);
   endtask

   int ord[$], tim[$], nack[N];

   initial begin
      for (int i = 0; i < (1 << 21); i++) mem[i] = 8'h00;
      for (int i = 0; i < N; i++) begin addr_v[i] = '0; wdata_v[i] = '0; end

      do_reset();
      check("reset_rdata", rdata, 0);
      check("reset_addr", sram_addr, 0);

      run_one(1, 1'b1, 20'h00010, 16'hF6A5);
      check("byte_lo", mem[21'h00020], 8'hA5);
      check("byte_hi", mem[21'h00021], 8'hF6);
      step();
      run_one(1, 1'b0, 20'h00010, 16'h0000);
      check("read_word", rdata, 16'hF6A5);
      drain();

      do_reset();
      for (int i = 0; i < N; i++) begin nack[i] = 0; new_op(i); end
      req = '1;
      for (int s = 0; s < 80 && req != '0; s++) begin
         step();
         for (int i = 0; i < N; i++) if (ack[i]) begin
            ord.push_back(i); tim.push_back(cyc); nack[i]++;
            if (nack[i] == 2) req[i] = 1'b0; else new_op(i);
         end
      end
      check("contention_count", ord.size(), 6);
      for (int i = 0; i < ord.size() && i < 6; i++) begin
         check("rr_order", ord[i], i % N);
         if (i > 0) check("ack_spacing", tim[i] - tim[i-1], 2*A + 2);
      end
      drain();

      req_we[0] = 1'b1; addr_v[0] = 20'h00005; wdata_v[0] = 16'h1234; req[0] = 1'b1;
      repeat (3) step();
      reset = 1'b1; req = '0;
      step();
      check("rst_mid_ctl", {sram_ce, sram_oe, sram_we}, 3'b111);
      check("rst_mid_ack", ack, 0);
      reset = 1'b0;
      req_we = '0; addr_v[0] = 20'h00010; addr_v[2] = 20'h00010; req = 3'b101;
      step();
      check("rst_first_grant", grant, 3'b001);
      drain();
      check("rst_half_lo", mem[21'h0000A], 8'h34);

      run_one(0, 1'b1, 20'hFFFFF, 16'hDABE);
      check("top_lo", mem[21'h1FFFFE], 8'hBE);
      check("top_hi", mem[21'h1FFFFF], 8'hDA);
      step();
      run_one(0, 1'b0, 20'hFFFFF, 16'h0000);
      check("top_read", rdata, 16'hDABE);
      drain();

      req_we[2] = 1'b1; addr_v[2] = 20'h00030; wdata_v[2] = 16'h5A5A; req[2] = 1'b1;
      step(); step();
      addr_v[2] = 20'h00031; wdata_v[2] = 16'hFFFF;
      for (int s = 0; s < 20 && !ack[2]; s++) step();
      check("opchg_ack", ack, 3'b100);
      req = '0;
      drain();
      check("opchg_lo", mem[21'h00060], 8'h5A);
      check("opchg_hi", mem[21'h00061], 8'h5A);
      check("opchg_untouched", mem[21'h00062], 8'h00);

      for (int s = 0; s < 1500; s++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (req[i] && m_ack[i]) begin
               if ($urandom_range(1, 0) == 1) new_op(i); else req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(3, 0) == 0) begin new_op(i); req[i] = 1'b1; end
            end else begin
               if ($urandom_range(3, 0) == 0) new_op(i);
               if (i == m_owner && $urandom_range(31, 0) == 0) req[i] = 1'b0;
            end
         end
      end
      drain();

      // ACCESS_CYCLES = 3 pin timing on the second instance
      req_we3 = 3'b001; req_addr3[AW-1:0] = 20'h00123; req_wdata3[15:0] = 16'hC3E1; req3 = 3'b001;
      for (int k = 1; k <= 2*A3 + 1; k++) begin
         @(negedge clk);
         if (k <= 2*A3) begin
            check("p3_ce_oe", {ce3, oe3}, 2'b01);
            check("p3_we", we3, ((k - 1) % A3) == A3 - 1);
            check("p3_addr", addr3, {20'h00123, k > A3});
            check("p3_data", data3, (k > A3) ? 8'hC3 : 8'hE1);
         end else begin
            check("p3_ack", ack3, 3'b001);
            check("p3_done_ctl", {ce3, oe3, we3}, 3'b111);
            req3 = '0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
